// File: rtl/dadda_final_adder.sv
// Final carry-propagate adder behind a Dadda reduction tree: sums the two reduced
// rows SLICE bits per cycle with a rippled carry, under a valid/ready handshake.
module dadda_final_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] row0,
  input  logic [WIDTH-1:0] row1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product,
  output logic             cout
);

  localparam int NSL  = WIDTH / SLICE;
  localparam int IDXW = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSL - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_row0;
  logic [WIDTH-1:0] r_row1;
  logic [WIDTH-1:0] r_product;
  logic             r_carry;
  logic             r_cout;
  logic [IDXW-1:0]  r_idx;

  logic [SLICE-1:0] w_a;
  logic [SLICE-1:0] w_b;
  logic [SLICE:0]   w_sum;
  logic             w_last;

  // Select the current slice of each held row by comparing against every
  // constant slice position, which keeps all part-selects static.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int s = 0; s < NSL; s++) begin
      if (r_idx == IDXW'(s)) begin
        w_a = r_row0[s*SLICE +: SLICE];
        w_b = r_row1[s*SLICE +: SLICE];
      end
    end
  end

  assign w_sum  = {1'b0, w_a} + {1'b0, w_b} + {{SLICE{1'b0}}, r_carry};
  assign w_last = (r_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_ADD;
      end
      S_ADD: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: rows captured on accept, one slice retired per ADD cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row0    <= '0;
      r_row1    <= '0;
      r_product <= '0;
      r_carry   <= 1'b0;
      r_cout    <= 1'b0;
      r_idx     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_row0  <= row0;
            r_row1  <= row1;
            r_carry <= 1'b0;
            r_idx   <= '0;
          end
        end
        S_ADD: begin
          for (int s = 0; s < NSL; s++) begin
            if (r_idx == IDXW'(s)) r_product[s*SLICE +: SLICE] <= w_sum[SLICE-1:0];
          end
          r_carry <= w_sum[SLICE];
          if (w_last) begin
            r_cout <= w_sum[SLICE];
            r_idx  <= '0;
          end else begin
            r_idx  <= r_idx + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign product = r_product;
  assign cout    = r_cout;

endmodule

// File: tb/tb_dadda_final_adder.sv
// Bench for dadda_final_adder: directed corner sums, backpressure, reset in
// flight and a back-to-back random stream against a plain-arithmetic model.
module tb_dadda_final_adder;

  localparam int WIDTH = 16;
  localparam int SLICE = 4;
  localparam int LAT   = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] row0;
  logic [WIDTH-1:0] row1;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] product;
  logic             cout;

  int checks = 0;
  int errors = 0;

  dadda_final_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .row0(row0), .row1(row1), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .cout(cout)
  );

  always #5 clk = ~clk;

  // Reference: full-precision sum of the two rows.
  function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; row0 = '0; row1 = '0;
    repeat (2) @(negedge clk);
    // Input offered while reset is held must not be accepted.
    in_valid = 1'b1; row0 = 16'h1234; row1 = 16'h1111;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_product got=%h exp=0000", product); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", cout); end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] va [3];
    logic [WIDTH-1:0] vb [3];
    logic [WIDTH:0]   exp;
    va[0] = 16'hFE00; vb[0] = 16'h0001;
    va[1] = 16'hFFFF; vb[1] = 16'h0001;
    va[2] = 16'h0F0F; vb[2] = 16'h00F1;
    out_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      exp = ref_sum(va[v], vb[v]);
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready got=%b exp=1", v, in_ready); end
      in_valid = 1'b1; row0 = va[v]; row1 = vb[v];
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_early_valid k=0 got=%b exp=0", v, out_valid); end
      for (int k = 1; k <= LAT; k++) begin
        @(negedge clk);
        checks++;
        if (out_valid !== (k == LAT)) begin
          errors++; $display("FAIL dir%0d_latency k=%0d got=%b exp=%b", v, k, out_valid, (k == LAT));
        end
      end
      checks++; if (product !== exp[WIDTH-1:0]) begin errors++; $display("FAIL dir%0d_product got=%h exp=%h", v, product, exp[WIDTH-1:0]); end
      checks++; if (cout !== exp[WIDTH]) begin errors++; $display("FAIL dir%0d_cout got=%b exp=%b", v, cout, exp[WIDTH]); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL dir%0d_return_idle out_valid=%b in_ready=%b exp 0/1", v, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; row0 = 16'h1234; row1 = 16'h4321;
    @(negedge clk);
    // Competing input while busy: must be ignored.
    row0 = 16'hFFFF; row1 = 16'hFFFF;
    repeat (LAT - 1) @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c=%0d got=%b exp=1", c, out_valid); end
      checks++; if (product !== 16'h5555 || cout !== 1'b0) begin
        errors++; $display("FAIL bp_hold c=%0d got=%h/%b exp=5555/0", c, product, cout);
      end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c=%0d got=%b exp=0", c, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_single_transfer got=%b exp=0", out_valid); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_spurious c=%0d got=%b exp=0", c, out_valid); end
    end
  endtask

  task automatic test_reset_mid_add();
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; row0 = 16'h1111; row1 = 16'h2222;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
    checks++; if (product !== 16'h0000 || cout !== 1'b0) begin
      errors++; $display("FAIL rst_mid_product got=%h/%b exp=0000/0", product, cout);
    end
    for (int c = 0; c < 8; c++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_valid c=%0d got=%b exp=0", c, out_valid); end
      @(negedge clk);
    end
    in_valid = 1'b1; row0 = 16'h0002; row1 = 16'h0003;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (LAT) @(negedge clk);
    checks++; if (out_valid !== 1'b1 || product !== 16'h0005 || cout !== 1'b0) begin
      errors++; $display("FAIL rst_mid_next got=%b/%h/%b exp=1/0005/0", out_valid, product, cout);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] a [8];
    logic [WIDTH-1:0] b [8];
    logic [WIDTH:0]   expq [$];
    logic [WIDTH:0]   e;
    int sent = 0, got = 0, cyc = 0, last_cyc = -1;
    logic acc;
    for (int i = 0; i < 8; i++) begin
      a[i] = WIDTH'($urandom);
      b[i] = WIDTH'($urandom);
    end
    a[0] = 16'hFFFF; b[0] = 16'hFFFF;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; row0 = a[0]; row1 = b[0];
    acc = in_ready && in_valid;
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (acc) begin
        expq.push_back(ref_sum(a[sent], b[sent]));
        sent++;
        if (sent < 8) begin row0 = a[sent]; row1 = b[sent]; end
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        if (expq.size() == 0) begin
          checks++; errors++; $display("FAIL b2b_unexpected cyc=%0d got=%h exp=none", cyc, product);
        end else begin
          e = expq.pop_front();
          checks++; if ({cout, product} !== e) begin
            errors++; $display("FAIL b2b_result n=%0d got=%b/%h exp=%b/%h", got, cout, product, e[WIDTH], e[WIDTH-1:0]);
          end
          if (got > 0) begin
            checks++; if (cyc - last_cyc != LAT + 2) begin
              errors++; $display("FAIL b2b_spacing n=%0d got=%0d exp=%0d", got, cyc - last_cyc, LAT + 2);
            end
          end
        end
        last_cyc = cyc;
        got++;
      end
      acc = in_ready && in_valid;
    end
    in_valid = 1'b0;
    checks++; if (got != 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", got); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra c=%0d got=%b exp=0", c, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_add();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
